lcd_timing_gen: RTL and testbench

//  Raster timing generator and pixel pacer between the SD-card frame source and the LVDS transmitter inside comp.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_sync_cnt.sv | 62 ++++++
 rtl/lcd_timing_gen.sv | 197 +++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared types and constants for the LCD raster timing generator:
//            pixel width, stream FSM state encoding and the colour-bar table.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam int c_RGB_W = 24;

  typedef logic [c_RGB_W-1:0] rgb_t;

  typedef enum logic [0:0] {
    SYNC_WAIT = 1'b0,
    LOCKED    = 1'b1
  } lcd_state_e;

  // Eight vertical bars, left to right, in classic descending-luma order.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;  // white
      3'd1:    return 24'hFFFF00;  // yellow
      3'd2:    return 24'h00FFFF;  // cyan
      3'd3:    return 24'h00FF00;  // green
      3'd4:    return 24'hFF00FF;  // magenta
      3'd5:    return 24'hFF0000;  // red
      3'd6:    return 24'h0000FF;  // blue
      default: return 24'h000000;  // black
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_sync_cnt.sv
`default_nettype none
// ============================================================================
// Module   : lcd_sync_cnt
// Brief    : Horizontal/vertical raster counters with combinational decode of
//            the active window, sync windows and the first pixel of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_sync_cnt #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int H_W      = 11,
  parameter int V_W      = 10
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  output logic [H_W-1:0] o_h_cnt,
  output logic           o_active,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_first
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;
  logic           w_h_wrap;
  logic           w_v_wrap;

  assign w_h_wrap = (r_h_cnt == H_W'(c_H_TOTAL - 1));
  assign w_v_wrap = (r_v_cnt == V_W'(c_V_TOTAL - 1));

  // Free-running raster position; vertical count advances on each line wrap.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt  = r_h_cnt;
  assign o_active = (r_h_cnt < H_W'(H_ACTIVE)) && (r_v_cnt < V_W'(V_ACTIVE));
  assign o_hs     = (r_h_cnt >= H_W'(H_ACTIVE + H_FP)) &&
                    (r_h_cnt <  H_W'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vs     = (r_v_cnt >= V_W'(V_ACTIVE + V_FP)) &&
                    (r_v_cnt <  V_W'(V_ACTIVE + V_FP + V_SYNC));
  assign o_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_gen
// Brief    : Raster timing generator and pixel pacer. Pulls pixels from a
//            valid/ready stream at the panel rate (or shows a colour-bar test
//            pattern) and drives registered DE/HS/VS/RGB to the LVDS tx.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timing_gen #(
  parameter int          H_ACTIVE  = 1024,
  parameter int          H_FP      = 40,
  parameter int          H_SYNC    = 128,
  parameter int          H_BP      = 88,
  parameter int          V_ACTIVE  = 600,
  parameter int          V_FP      = 1,
  parameter int          V_SYNC    = 4,
  parameter int          V_BP      = 23,
  parameter logic        HS_POL    = 1'b0,
  parameter logic        VS_POL    = 1'b0,
  parameter logic [23:0] UFLOW_RGB = 24'hFF0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        display_sel,
  input  logic [23:0] s_data_i,
  input  logic        s_sof_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic [23:0] rgb_o,
  output logic        de_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        frame_start_o,
  output logic        underflow_o,
  output logic        locked_o
);

  import lcd_pkg::*;

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_H_W     = $clog2(c_H_TOTAL + 1);
  localparam int c_V_W     = $clog2(c_V_TOTAL + 1);
  localparam int c_BAR_PIX = H_ACTIVE / 8;

  logic [c_H_W-1:0] w_h_cnt;
  logic             w_active;
  logic             w_hs;
  logic             w_vs;
  logic             w_first;
  logic [2:0]       w_bar_idx;
  logic             w_mode;
  logic             w_head_sof;
  logic             w_ready;
  logic             w_uflow;
  rgb_t             w_rgb;
  lcd_state_e       w_state_nxt;

  logic             r_mode;
  lcd_state_e       r_state;
  rgb_t             r_rgb;
  logic             r_de;
  logic             r_hs;
  logic             r_vs;
  logic             r_fs;
  logic             r_uflow;
  logic             r_locked;

  lcd_sync_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_W      (c_H_W),
    .V_W      (c_V_W)
  ) u_sync_cnt (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .o_h_cnt  (w_h_cnt),
    .o_active (w_active),
    .o_hs     (w_hs),
    .o_vs     (w_vs),
    .o_first  (w_first)
  );

  assign w_bar_idx = 3'(w_h_cnt / c_H_W'(c_BAR_PIX));

  // The frame's first pixel already obeys the newly sampled mode, so the
  // switch lines up exactly with frame_start_o.
  assign w_mode     = w_first ? display_sel : r_mode;
  assign w_head_sof = s_valid_i & s_sof_i;
  assign s_ready_o  = w_ready;

  // Mode latch: display_sel is only honoured at the top-left pixel.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_mode <= 1'b1;
    end else if (w_first) begin
      r_mode <= display_sel;
    end
  end

  // Stream alignment FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= SYNC_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, stream handshake and pixel selection for the current position.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_uflow     = 1'b0;
    w_rgb       = '0;
    if (!w_mode) begin
      // Test pattern: keep the stream drained and force realignment later.
      w_state_nxt = SYNC_WAIT;
      w_ready     = 1'b1;
      if (w_active) begin
        w_rgb = bar_colour(w_bar_idx);
      end
    end else begin
      case (r_state)
        SYNC_WAIT: begin
          // Drop everything up to an SOF, then park it until the raster top.
          w_ready = ~w_head_sof | w_first;
          if (w_active) begin
            w_rgb = UFLOW_RGB;
          end
          if (w_first && w_head_sof) begin
            w_state_nxt = LOCKED;
            w_rgb       = s_data_i;
          end
        end
        LOCKED: begin
          if (w_active) begin
            if (!s_valid_i) begin
              w_rgb       = UFLOW_RGB;
              w_uflow     = 1'b1;
              w_state_nxt = SYNC_WAIT;
            end else if (s_sof_i && !w_first) begin
              // Short frame: leave the next frame's SOF at the head.
              w_rgb       = UFLOW_RGB;
              w_state_nxt = SYNC_WAIT;
            end else if (!s_sof_i && w_first) begin
              // Long frame: the surplus pixel is consumed and dropped.
              w_ready     = 1'b1;
              w_rgb       = UFLOW_RGB;
              w_state_nxt = SYNC_WAIT;
            end else begin
              w_ready = 1'b1;
              w_rgb   = s_data_i;
            end
          end
        end
      endcase
    end
  end

  // Output registers: everything reaches the pins one cycle after its position.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rgb    <= '0;
      r_de     <= 1'b0;
      r_hs     <= ~HS_POL;
      r_vs     <= ~VS_POL;
      r_fs     <= 1'b0;
      r_uflow  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_rgb    <= w_rgb;
      r_de     <= w_active;
      r_hs     <= w_hs ? HS_POL : ~HS_POL;
      r_vs     <= w_vs ? VS_POL : ~VS_POL;
      r_fs     <= w_first;
      r_uflow  <= w_uflow;
      r_locked <= (w_state_nxt == LOCKED);
    end
  end

  assign rgb_o         = r_rgb;
  assign de_o          = r_de;
  assign hs_o          = r_hs;
  assign vs_o          = r_vs;
  assign frame_start_o = r_fs;
  assign underflow_o   = r_uflow;
  assign locked_o      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_timing_gen
// Brief    : Directed bench for lcd_timing_gen on a reduced 22x7 raster.
//            Source beats and expected active pixels are queued per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_gen;

  localparam int H_TOT = 22;
  localparam int V_TOT = 7;
  localparam logic [23:0] UF = 24'hFF0000;

  typedef struct packed { logic v; logic sof; logic [23:0] d; } beat_t;
  typedef struct packed { logic [23:0] rgb; logic uf; logic lk; } exp_t;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        display_sel = 1'b0;
  logic [23:0] s_data_i = '0;
  logic        s_sof_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [23:0] rgb_o;
  logic        de_o, hs_o, vs_o, frame_start_o, underflow_o, locked_o;

  beat_t src[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    bh = 0;
  int    bv = 0;
  bit    rdy_chk = 1'b0;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .display_sel   (display_sel),
    .s_data_i      (s_data_i),
    .s_sof_i       (s_sof_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .rgb_o         (rgb_o),
    .de_o          (de_o),
    .hs_o          (hs_o),
    .vs_o          (vs_o),
    .frame_start_o (frame_start_o),
    .underflow_o   (underflow_o),
    .locked_o      (locked_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar(input int p);
    logic [23:0] tbl [8];
    tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return tbl[(p % 16) / 2];
  endfunction

  // Queue one source frame of n ramp pixels; an idle beat precedes pixel gap_at.
  task automatic src_frame(input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) src.push_back('{v: 1'b0, sof: 1'b0, d: 24'h0});
      src.push_back('{v: 1'b1, sof: (i == 0), d: 24'(i)});
    end
  endtask

  task automatic exp_push(input logic [23:0] rgb, input logic uf, input logic lk);
    sb.push_back('{rgb: rgb, uf: uf, lk: lk});
  endtask

  task automatic exp_ramp();
    for (int p = 0; p < 64; p++) exp_push(24'(p), 1'b0, 1'b1);
  endtask

  task automatic exp_bars();
    for (int p = 0; p < 64; p++) exp_push(bar(p), 1'b0, 1'b0);
  endtask

  // One pixel clock: drive the source head, handshake, then check outputs.
  task automatic tick();
    bit   fire;
    exp_t e;
    logic exp_de;
    if (src.size() > 0) begin
      s_valid_i = src[0].v;
      s_sof_i   = src[0].sof;
      s_data_i  = src[0].d;
    end else begin
      s_valid_i = 1'b0;
      s_sof_i   = 1'b0;
      s_data_i  = '0;
    end
    @(negedge clk);
    fire = s_valid_i & s_ready_o;
    if (rstn_i && rdy_chk && !(bh < 16 && bv < 4))
      chk("ready_blank", {31'd0, s_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    if (src.size() > 0 && (fire || !src[0].v)) void'(src.pop_front());
    if (!rstn_i) begin
      chk("reset_out", {2'b00, rgb_o, de_o, hs_o, vs_o, frame_start_o, underflow_o, locked_o},
          {2'b00, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    end else begin
      exp_de = (bh < 16) && (bv < 4);
      chk("sync", {28'd0, de_o, hs_o, vs_o, frame_start_o},
          {28'd0, exp_de, !(bh >= 18 && bh < 20), !(bv == 5), (bh == 0 && bv == 0)});
      if (de_o) begin
        chk("sb_avail", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pix_rgb", {8'd0, rgb_o}, {8'd0, e.rgb});
          chk("pix_flags", {30'd0, underflow_o, locked_o}, {30'd0, e.uf, e.lk});
        end
      end else begin
        chk("blank_out", {7'd0, rgb_o, underflow_o}, 32'd0);
      end
      bh++;
      if (bh == H_TOT) begin
        bh = 0;
        bv = (bv == V_TOT - 1) ? 0 : bv + 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset for five cycles with the test pattern selected.
    rstn_i = 1'b0;
    display_sel = 1'b0;
    run(5);
    rstn_i = 1'b1;

    // F0: colour bars.
    exp_bars();
    run(154);

    // F1: stream mode, clean ramp, locks on first frame.
    display_sel = 1'b1;
    src_frame(64, -1);
    exp_ramp();
    run(154);

    // F2: steady lock, ready must stay low through blanking.
    rdy_chk = 1'b1;
    src_frame(64, -1);
    exp_ramp();
    run(154);
    rdy_chk = 1'b0;

    // F3: one starved active cycle at pixel 10.
    src_frame(64, 10);
    for (int p = 0; p < 64; p++) begin
      if (p < 10)       exp_push(24'(p), 1'b0, 1'b1);
      else if (p == 10) exp_push(UF, 1'b1, 1'b0);
      else              exp_push(UF, 1'b0, 1'b0);
    end
    run(154);

    // F4: relock on the next SOF frame.
    src_frame(64, -1);
    exp_ramp();
    run(154);

    // F5: 63-pixel frame followed immediately by a full frame.
    src_frame(63, -1);
    src_frame(64, -1);
    for (int p = 0; p < 63; p++) exp_push(24'(p), 1'b0, 1'b1);
    exp_push(UF, 1'b0, 1'b0);
    run(154);

    // F6: the parked SOF relocks.
    exp_ramp();
    run(154);

    // F7: 65-pixel frame, all 64 displayed.
    src_frame(65, -1);
    exp_ramp();
    run(154);

    // F8: surplus pixel hits the top-left slot, whole frame unlocked.
    src_frame(64, -1);
    for (int p = 0; p < 64; p++) exp_push(UF, 1'b0, 1'b0);
    run(154);

    // F9: relock on the held SOF.
    exp_ramp();
    run(154);

    // F10: display_sel dropped mid-frame; stream keeps playing.
    src_frame(64, -1);
    exp_ramp();
    run(30);
    display_sel = 1'b0;
    run(124);

    // F11: the new mode takes effect at this frame start.
    exp_bars();
    run(154);

    // F12: back to stream, then reset in the middle of an active line.
    display_sel = 1'b1;
    src_frame(64, -1);
    exp_ramp();
    run(30);
    src.delete();
    sb.delete();
    rstn_i = 1'b0;
    run(3);
    rstn_i = 1'b1;
    bh = 0;
    bv = 0;

    // F13: raster restarts at (0,0) in test pattern mode.
    display_sel = 1'b0;
    exp_bars();
    run(154);

    // F14: stream locks again after the restart.
    display_sel = 1'b1;
    src_frame(64, -1);
    exp_ramp();
    run(154);

    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
